pov_frame_scheduler: RTL

//  Sequences WS2812 strip refreshes for the POV display. Watches the angle index (theta) and launches
//  one full strip frame per new angular column, holding the texture column stable for that frame.

---
 rtl/pov_frame_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pov_frame_scheduler.sv
// POV strip frame scheduler: launches one strip frame per new theta column and swaps banks at revolution wrap.
// Optional watchdog on the ACTIVE state is enabled with `define FRAME_TIMEOUT_EN.
module pov_frame_scheduler #(
  parameter int THETA_BITS     = 6,
  parameter int TEX_WIDTH      = 256,
  parameter int BANK_BITS      = 2,
  parameter int OVR_BITS       = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [THETA_BITS-1:0]        theta,
  input  logic                         strip_done,
  input  logic                         cpu_bank_wr,
  input  logic [BANK_BITS-1:0]         cpu_bank_data,
  output logic                         strip_start,
  output logic [$clog2(TEX_WIDTH)-1:0] col,
  output logic [BANK_BITS-1:0]         bank,
  output logic                         busy,
  output logic                         rev_pulse,
  output logic [OVR_BITS-1:0]          overrun_cnt,
  output logic                         timeout_flag
);

  localparam int COL_W  = $clog2(TEX_WIDTH);
  localparam int PROD_W = THETA_BITS + COL_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  // Strip handshake: strip_start is a one-cycle request issued from START; the
  // strip controller answers with a one-cycle strip_done, honoured only in ACTIVE.
  state_t state_q, state_d;

  logic [THETA_BITS-1:0] last_theta_q, last_theta_d;
  logic                  pend_q, pend_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [BANK_BITS-1:0]  bank_q, bank_d;
  logic [BANK_BITS-1:0]  bank_pend_q, bank_pend_d;
  logic                  bank_pend_v_q, bank_pend_v_d;
  logic                  rev_pulse_q, rev_pulse_d;
  logic [OVR_BITS-1:0]   overrun_cnt_q, overrun_cnt_d;

  logic              change;
  logic              wrap;
  logic              launch;
  logic              timeout_hit;
  logic [PROD_W-1:0] col_prod;

  assign change   = (theta != last_theta_q);
  assign wrap     = change && (theta < last_theta_q);
  assign launch   = (state_q == IDLE) && pend_q;
  assign col_prod = PROD_W'(last_theta_q) * PROD_W'(TEX_WIDTH);

`ifdef FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_flag_q, timeout_flag_d;

  assign timeout_hit = (state_q == ACTIVE) && !strip_done &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d      = tmo_cnt_q;
    timeout_flag_d = timeout_flag_q;
    if (state_q == START) tmo_cnt_d = '0;
    else if (state_q == ACTIVE) tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (timeout_hit) timeout_flag_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q      <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      tmo_cnt_q      <= tmo_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

  assign timeout_flag = timeout_flag_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pend_q) state_d = START;
      START:   state_d = ACTIVE;
      ACTIVE:  if (strip_done || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    strip_start = 1'b0;
    busy        = 1'b0;
    case (state_q)
      START:   begin strip_start = 1'b1; busy = 1'b1; end
      ACTIVE:  busy = 1'b1;
      default: ;
    endcase
  end

  // Datapath: theta change tracking, column latch, overrun counting, bank staging
  always_comb begin
    last_theta_d  = last_theta_q;
    pend_d        = pend_q;
    col_d         = col_q;
    bank_d        = bank_q;
    bank_pend_d   = bank_pend_q;
    bank_pend_v_d = bank_pend_v_q;
    overrun_cnt_d = overrun_cnt_q;
    rev_pulse_d   = wrap;

    if (launch) begin
      col_d  = COL_W'(col_prod >> THETA_BITS);
      pend_d = 1'b0;
    end

    // A change overrides the launch clear so the new column gets its own frame.
    if (change) begin
      last_theta_d = theta;
      pend_d       = 1'b1;
      if (pend_q && (state_q != IDLE) && (overrun_cnt_q != {OVR_BITS{1'b1}}))
        overrun_cnt_d = overrun_cnt_q + 1'b1;
    end

    if (cpu_bank_wr) begin
      bank_pend_d   = cpu_bank_data;
      bank_pend_v_d = 1'b1;
    end

    if (wrap && (bank_pend_v_q || cpu_bank_wr)) begin
      bank_d        = cpu_bank_wr ? cpu_bank_data : bank_pend_q;
      bank_pend_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_theta_q  <= '0;
      pend_q        <= 1'b1;
      col_q         <= '0;
      bank_q        <= '0;
      bank_pend_q   <= '0;
      bank_pend_v_q <= 1'b0;
      rev_pulse_q   <= 1'b0;
      overrun_cnt_q <= '0;
    end else begin
      last_theta_q  <= last_theta_d;
      pend_q        <= pend_d;
      col_q         <= col_d;
      bank_q        <= bank_d;
      bank_pend_q   <= bank_pend_d;
      bank_pend_v_q <= bank_pend_v_d;
      rev_pulse_q   <= rev_pulse_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign col         = col_q;
  assign bank        = bank_q;
  assign rev_pulse   = rev_pulse_q;
  assign overrun_cnt = overrun_cnt_q;

endmodule
